// File: rtl/dmem_ctrl.sv
// Data-memory controller: MEM-stage load/store to a 64-bit bus, lane steering and flush draining.
// Latency: 3 cycles min (accept, addr handshake, response, done pulse); holds address phase until bus_ready_i.
module dmem_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [63:0] mem_addr_i,
  input  logic [63:0] mem_wdata_i,
  input  logic [3:0]  mem_size_i,
  input  logic        flush_i,
  output logic        bus_valid_o,
  input  logic        bus_ready_i,
  output logic        bus_we_o,
  output logic [63:0] bus_addr_o,
  output logic [63:0] bus_wdata_o,
  output logic [7:0]  bus_wstrb_o,
  input  logic        bus_rvalid_i,
  input  logic [63:0] bus_rdata_i,
  input  logic [1:0]  bus_resp_i,
  output logic        stall_o,
  output logic [63:0] dm_o,
  output logic        done_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [63:3] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  mask_q, mask_d;
  logic [2:0]  off_q, off_d;
  logic        drain_q, drain_d;
  logic        err_q, err_d;
  logic [63:0] dm_q, dm_d;

  logic [7:0]  req_mask;
  logic        req_misaligned;
  logic        accept;
  logic [63:0] lane_mask;
  logic [63:0] rd_shifted;

  // Highest set size bit wins; an all-zero size is treated as no access.
  always_comb begin
    req_mask       = 8'h00;
    req_misaligned = 1'b0;
    casez (mem_size_i)
      4'b1???: begin
        req_mask       = 8'hFF;
        req_misaligned = (mem_addr_i[2:0] != 3'd0);
      end
      4'b01??: begin
        req_mask       = 8'h0F;
        req_misaligned = (mem_addr_i[1:0] != 2'd0);
      end
      4'b001?: begin
        req_mask       = 8'h03;
        req_misaligned = mem_addr_i[0];
      end
      4'b0001: begin
        req_mask       = 8'h01;
        req_misaligned = 1'b0;
      end
      default: begin
        req_mask       = 8'h00;
        req_misaligned = 1'b0;
      end
    endcase
  end

  assign accept = (state_q == IDLE) && mem_req_i && (req_mask != 8'h00) &&
                  !req_misaligned && !flush_i;

  // Bit-level mask of the access width, before shifting into lanes.
  always_comb begin
    lane_mask = 64'd0;
    for (int i = 0; i < 8; i++) begin
      lane_mask[8*i +: 8] = {8{mask_q[i]}};
    end
  end

  assign rd_shifted = (bus_rdata_i >> {off_q, 3'b000}) & lane_mask;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    off_d   = off_q;
    drain_d = drain_q;
    err_d   = err_q;
    dm_d    = dm_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = mem_we_i;
          addr_d  = mem_addr_i[63:3];
          wdata_d = mem_wdata_i;
          mask_d  = req_mask;
          off_d   = mem_addr_i[2:0];
          drain_d = 1'b0;
          err_d   = 1'b0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        // A flush racing the handshake cannot cancel it; drain the response instead.
        if (bus_ready_i) begin
          drain_d = flush_i;
          state_d = DATA;
        end else if (flush_i) begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (bus_rvalid_i) begin
          if (drain_q || flush_i) begin
            drain_d = 1'b0;
            state_d = IDLE;
          end else begin
            err_d   = (bus_resp_i != 2'b00);
            if (!we_q && (bus_resp_i == 2'b00)) begin
              dm_d = rd_shifted;
            end
            state_d = DONE;
          end
        end else if (flush_i) begin
          drain_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 64'd0;
      mask_q  <= 8'h00;
      off_q   <= 3'd0;
      drain_q <= 1'b0;
      err_q   <= 1'b0;
      dm_q    <= 64'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      off_q   <= off_d;
      drain_q <= drain_d;
      err_q   <= err_d;
      dm_q    <= dm_d;
    end
  end

  // Bus fields come only from latched state so they stay stable under backpressure.
  assign bus_valid_o = (state_q == ADDR);
  assign bus_we_o    = we_q;
  assign bus_addr_o  = {addr_q, 3'b000};
  assign bus_wdata_o = (wdata_q & lane_mask) << {off_q, 3'b000};
  assign bus_wstrb_o = we_q ? (mask_q << off_q) : 8'h00;

  assign stall_o    = accept || (((state_q == ADDR) || (state_q == DATA)) && !drain_q);
  assign done_o     = (state_q == DONE);
  assign bus_err_o  = (state_q == DONE) && err_q;
  assign misalign_o = (state_q == IDLE) && mem_req_i && req_misaligned;
  assign dm_o       = dm_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: loads, stores, misalignment, backpressure, flush, errors, reset.
module tb_dmem_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [63:0] mem_addr_i;
  logic [63:0] mem_wdata_i;
  logic [3:0]  mem_size_i;
  logic        flush_i;
  logic        bus_valid_o;
  logic        bus_ready_i;
  logic        bus_we_o;
  logic [63:0] bus_addr_o;
  logic [63:0] bus_wdata_o;
  logic [7:0]  bus_wstrb_o;
  logic        bus_rvalid_i;
  logic [63:0] bus_rdata_i;
  logic [1:0]  bus_resp_i;
  logic        stall_o;
  logic [63:0] dm_o;
  logic        done_o;
  logic        misalign_o;
  logic        bus_err_o;

  int tests;
  int fails;

  dmem_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .mem_req_i   (mem_req_i),
    .mem_we_i    (mem_we_i),
    .mem_addr_i  (mem_addr_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_size_i  (mem_size_i),
    .flush_i     (flush_i),
    .bus_valid_o (bus_valid_o),
    .bus_ready_i (bus_ready_i),
    .bus_we_o    (bus_we_o),
    .bus_addr_o  (bus_addr_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_wstrb_o (bus_wstrb_o),
    .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i (bus_rdata_i),
    .bus_resp_i  (bus_resp_i),
    .stall_o     (stall_o),
    .dm_o        (dm_o),
    .done_o      (done_o),
    .misalign_o  (misalign_o),
    .bus_err_o   (bus_err_o)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=<200000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    mem_req_i    = 1'b0;
    mem_we_i     = 1'b0;
    mem_addr_i   = 64'd0;
    mem_wdata_i  = 64'd0;
    mem_size_i   = 4'd0;
    flush_i      = 1'b0;
    bus_ready_i  = 1'b0;
    bus_rvalid_i = 1'b0;
    bus_rdata_i  = 64'd0;
    bus_resp_i   = 2'b00;
  endtask

  task automatic request(input logic we, input logic [63:0] addr,
                         input logic [3:0] size, input logic [63:0] wdata);
    mem_req_i   = 1'b1;
    mem_we_i    = we;
    mem_addr_i  = addr;
    mem_size_i  = size;
    mem_wdata_i = wdata;
  endtask

  task automatic scramble_request();
    mem_req_i   = 1'b0;
    mem_we_i    = ~mem_we_i;
    mem_addr_i  = 64'hDEAD_0000_0000_0007;
    mem_wdata_i = 64'h5555_5555_5555_5555;
    mem_size_i  = 4'b0001;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    tests++;
    if (dm_o !== 64'd0 || done_o !== 1'b0 || bus_err_o !== 1'b0 || bus_valid_o !== 1'b0 ||
        stall_o !== 1'b0 || misalign_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: dm=%h done=%b err=%b valid=%b stall=%b mis=%b required all zero",
               dm_o, done_o, bus_err_o, bus_valid_o, stall_o, misalign_o);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_load_word();
    request(1'b0, 64'h0000_0000_8000_0004, 4'b0100, 64'd0);
    bus_ready_i  = 1'b1;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 64'h1234_5678_9ABC_DEF0;
    #1;
    tests++;
    if (stall_o !== 1'b1) begin fails++; $display("FAIL lw_accept_stall: got %b required 1", stall_o); end
    tick();
    scramble_request();
    #1;
    tests++;
    if (bus_valid_o !== 1'b1 || bus_addr_o !== 64'h0000_0000_8000_0000 || bus_wstrb_o !== 8'h00 || bus_we_o !== 1'b0) begin
      fails++;
      $display("FAIL lw_addr_phase: valid=%b addr=%h wstrb=%h we=%b required 1/0000000080000000/00/0",
               bus_valid_o, bus_addr_o, bus_wstrb_o, bus_we_o);
    end
    tick();
    tests++;
    if (done_o !== 1'b0 || stall_o !== 1'b1) begin
      fails++; $display("FAIL lw_data_phase: done=%b stall=%b required 0/1", done_o, stall_o);
    end
    tick();
    // Request presented in DONE must be ignored.
    request(1'b0, 64'h0000_0000_8000_0008, 4'b1000, 64'd0);
    #1;
    tests++;
    if (done_o !== 1'b1 || dm_o !== 64'h0000_0000_1234_5678 || bus_err_o !== 1'b0 || stall_o !== 1'b0) begin
      fails++;
      $display("FAIL lw_done_cycle3: done=%b dm=%h err=%b stall=%b required 1/0000000012345678/0/0",
               done_o, dm_o, bus_err_o, stall_o);
    end
    tick();
    mem_req_i = 1'b0;
    #1;
    tests++;
    if (done_o !== 1'b0 || bus_valid_o !== 1'b0) begin
      fails++; $display("FAIL lw_no_accept_in_done: done=%b valid=%b required 0/0", done_o, bus_valid_o);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_store_byte();
    int dones;
    request(1'b1, 64'h0000_0000_8000_0003, 4'b0001, 64'h0000_0000_0000_00AB);
    bus_ready_i  = 1'b1;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    scramble_request();
    #1;
    tests++;
    if (bus_wstrb_o !== 8'h08 || bus_wdata_o !== 64'h0000_0000_AB00_0000 || bus_we_o !== 1'b1 ||
        bus_addr_o !== 64'h0000_0000_8000_0000) begin
      fails++;
      $display("FAIL sb_lanes: wstrb=%h wdata=%h we=%b addr=%h required 08/00000000ab000000/1/0000000080000000",
               bus_wstrb_o, bus_wdata_o, bus_we_o, bus_addr_o);
    end
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done_o === 1'b1) dones++;
    end
    tests++;
    if (dones != 1) begin fails++; $display("FAIL sb_done_count: got %0d required 1", dones); end
    tests++;
    if (dm_o !== 64'h0000_0000_1234_5678) begin
      fails++; $display("FAIL sb_dm_unchanged: got %h required 0000000012345678", dm_o);
    end
    idle_inputs();
  endtask

  task automatic test_load_narrow();
    logic [63:0] addrs [2];
    logic [3:0]  sizes [2];
    logic [63:0] exps  [2];
    addrs[0] = 64'h8000_0005; sizes[0] = 4'b0001; exps[0] = 64'h33;
    addrs[1] = 64'h8000_0006; sizes[1] = 4'b0011; exps[1] = 64'h1122;
    for (int k = 0; k < 2; k++) begin
      request(1'b0, addrs[k], sizes[k], 64'd0);
      bus_ready_i  = 1'b1;
      bus_rvalid_i = 1'b1;
      bus_rdata_i  = 64'h1122_3344_5566_7788;
      tick();
      scramble_request();
      tick();
      tick();
      tests++;
      if (done_o !== 1'b1 || dm_o !== exps[k]) begin
        fails++; $display("FAIL narrow_load_%0d: done=%b dm=%h required 1/%h", k, done_o, dm_o, exps[k]);
      end
      idle_inputs();
      tick();
    end
  endtask

  task automatic test_misalign();
    request(1'b0, 64'h0000_0000_8000_0001, 4'b0010, 64'd0);
    bus_ready_i = 1'b1;
    #1;
    tests++;
    if (misalign_o !== 1'b1 || stall_o !== 1'b0 || bus_valid_o !== 1'b0) begin
      fails++; $display("FAIL mis_half: mis=%b stall=%b valid=%b required 1/0/0", misalign_o, stall_o, bus_valid_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (bus_valid_o !== 1'b0 || stall_o !== 1'b0) begin
        fails++; $display("FAIL mis_no_bus_%0d: valid=%b stall=%b required 0/0", i, bus_valid_o, stall_o);
      end
    end
    mem_addr_i = 64'h8000_0002; mem_size_i = 4'b0100;
    #1;
    tests++;
    if (misalign_o !== 1'b1) begin fails++; $display("FAIL mis_word: got %b required 1", misalign_o); end
    mem_addr_i = 64'h8000_0004; mem_size_i = 4'b1100;
    #1;
    tests++;
    if (misalign_o !== 1'b1) begin fails++; $display("FAIL mis_dword_priority: got %b required 1", misalign_o); end
    mem_size_i = 4'b0000;
    #1;
    tests++;
    if (misalign_o !== 1'b0 || stall_o !== 1'b0) begin
      fails++; $display("FAIL size_zero: mis=%b stall=%b required 0/0", misalign_o, stall_o);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_backpressure();
    request(1'b1, 64'h0000_0000_8000_0010, 4'b1000, 64'h0123_4567_89AB_CDEF);
    bus_ready_i  = 1'b0;
    bus_rvalid_i = 1'b0;
    tick();
    scramble_request();
    for (int c = 1; c <= 4; c++) begin
      bus_ready_i = (c == 4);
      #1;
      tests++;
      if (bus_valid_o !== 1'b1 || stall_o !== 1'b1 || bus_addr_o !== 64'h0000_0000_8000_0010 ||
          bus_wdata_o !== 64'h0123_4567_89AB_CDEF || bus_wstrb_o !== 8'hFF || bus_we_o !== 1'b1) begin
        fails++;
        $display("FAIL bp_hold_c%0d: valid=%b stall=%b addr=%h wdata=%h wstrb=%h we=%b required 1/1/0000000080000010/0123456789abcdef/ff/1",
                 c, bus_valid_o, stall_o, bus_addr_o, bus_wdata_o, bus_wstrb_o, bus_we_o);
      end
      tick();
    end
    bus_ready_i = 1'b0;
    for (int c = 5; c <= 6; c++) begin
      bus_rvalid_i = (c == 6);
      #1;
      tests++;
      if (stall_o !== 1'b1 || done_o !== 1'b0 || bus_valid_o !== 1'b0) begin
        fails++; $display("FAIL bp_data_c%0d: stall=%b done=%b valid=%b required 1/0/0", c, stall_o, done_o, bus_valid_o);
      end
      tick();
    end
    tests++;
    if (done_o !== 1'b1 || dm_o !== 64'h1122) begin
      fails++; $display("FAIL bp_done_c7: done=%b dm=%h required 1/0000000000001122", done_o, dm_o);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_flush();
    // Flush in IDLE drops the request.
    request(1'b0, 64'h8000_0000, 4'b0100, 64'd0);
    flush_i     = 1'b1;
    bus_ready_i = 1'b1;
    #1;
    tests++;
    if (stall_o !== 1'b0) begin fails++; $display("FAIL flush_idle_stall: got %b required 0", stall_o); end
    tick();
    tests++;
    if (bus_valid_o !== 1'b0) begin fails++; $display("FAIL flush_idle_valid: got %b required 0", bus_valid_o); end
    // Flush in ADDR before the handshake.
    flush_i = 1'b0; bus_ready_i = 1'b0;
    tick();
    scramble_request();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    #1;
    tests++;
    if (bus_valid_o !== 1'b0 || done_o !== 1'b0 || stall_o !== 1'b0) begin
      fails++; $display("FAIL flush_addr: valid=%b done=%b stall=%b required 0/0/0", bus_valid_o, done_o, stall_o);
    end
    tick();
    // Flush in DATA discards the read data.
    request(1'b0, 64'h8000_0000, 4'b0100, 64'd0);
    bus_ready_i = 1'b1; bus_rvalid_i = 1'b0; bus_rdata_i = 64'hAAAA_AAAA_AAAA_AAAA;
    tick();
    scramble_request();
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0; bus_rvalid_i = 1'b1;
    #1;
    tests++;
    if (stall_o !== 1'b0 || done_o !== 1'b0) begin
      fails++; $display("FAIL flush_data_drain: stall=%b done=%b required 0/0", stall_o, done_o);
    end
    tick();
    // Back in IDLE: a fresh half read gets an error response.
    request(1'b0, 64'h8000_0002, 4'b0010, 64'd0);
    bus_resp_i = 2'b10; bus_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    tests++;
    if (done_o !== 1'b0 || dm_o !== 64'h1122 || stall_o !== 1'b1) begin
      fails++; $display("FAIL flush_data_idle: done=%b dm=%h stall=%b required 0/0000000000001122/1", done_o, dm_o, stall_o);
    end
    tick();
    scramble_request();
    tick();
    tick();
    tests++;
    if (done_o !== 1'b1 || bus_err_o !== 1'b1 || dm_o !== 64'h1122) begin
      fails++; $display("FAIL err_resp: done=%b err=%b dm=%h required 1/1/0000000000001122", done_o, bus_err_o, dm_o);
    end
    tick();
    tests++;
    if (bus_err_o !== 1'b0 || done_o !== 1'b0) begin
      fails++; $display("FAIL err_pulse_len: err=%b done=%b required 0/0", bus_err_o, done_o);
    end
    // Flush coinciding with the address handshake still drains.
    idle_inputs();
    request(1'b0, 64'h8000_0000, 4'b1000, 64'd0);
    bus_ready_i = 1'b1;
    tick();
    scramble_request();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0; bus_ready_i = 1'b0; bus_rvalid_i = 1'b1; bus_resp_i = 2'b01;
    #1;
    tests++;
    if (stall_o !== 1'b0 || bus_valid_o !== 1'b0) begin
      fails++; $display("FAIL flush_hs_drain: stall=%b valid=%b required 0/0", stall_o, bus_valid_o);
    end
    tick();
    tests++;
    if (done_o !== 1'b0 || bus_err_o !== 1'b0 || dm_o !== 64'h1122) begin
      fails++; $display("FAIL flush_hs_discard: done=%b err=%b dm=%h required 0/0/0000000000001122", done_o, bus_err_o, dm_o);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_in_data();
    request(1'b0, 64'h8000_0008, 4'b1000, 64'd0);
    bus_ready_i = 1'b1; bus_rvalid_i = 1'b0;
    tick();
    scramble_request();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 64'h0BAD_0BAD_0BAD_0BAD;
    #1;
    tests++;
    if (dm_o !== 64'd0 || stall_o !== 1'b0 || bus_valid_o !== 1'b0 || done_o !== 1'b0) begin
      fails++; $display("FAIL rst_data_state: dm=%h stall=%b valid=%b done=%b required 0/0/0/0", dm_o, stall_o, bus_valid_o, done_o);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++;
      if (done_o !== 1'b0 || dm_o !== 64'd0 || bus_err_o !== 1'b0) begin
        fails++; $display("FAIL rst_data_ignore_%0d: done=%b dm=%h err=%b required 0/0/0", i, done_o, dm_o, bus_err_o);
      end
    end
    idle_inputs();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_load_word();
    test_store_byte();
    test_load_narrow();
    test_misalign();
    test_backpressure();
    test_flush();
    test_reset_in_data();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
